// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Responder side of the core's data-memory port. It accepts one load/store at
//   a time over a valid/ready handshake and inserts WAIT_CYCLES wait states. It
//   then performs a byte-strobed word access on internal storage. Finally it
//   holds a response (read data + error flag) until the requester takes it.
//
// Parameters
//   DEPTH_WORDS  storage size in 32-bit words (power of two, >= 4)
//   WAIT_CYCLES  wait states between accept and response (0..15)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_valid_i  request present, payload stable until accepted
//   req_ready_o  responder can accept (registered)
//   req_write_i  1 = store, 0 = load
//   req_addr_i   byte address
//   req_wdata_i  store data
//   req_wstrb_i  store byte enables, bit i -> req_wdata_i[8i+7:8i]
//   rsp_valid_o  response present, held until rsp_ready_i (registered)
//   rsp_ready_i  requester accepts response
//   rsp_rdata_o  load data; 0 for stores and errored accesses (registered)
//   rsp_err_o    misaligned or out-of-range access (registered)
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [3:0]  req_wstrb_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t             state_q;
   logic [3:0]         cnt_q;
   logic               write_q;
   logic [IDX_W-1:0]   idx_q;
   logic [31:0]        wdata_q;
   logic [3:0]         wstrb_q;
   logic               err_q;
   logic               req_ready_q;
   logic               rsp_valid_q;
   logic [31:0]        rsp_rdata_q;
   logic               rsp_err_q;

   logic [31:0]        mem_q [DEPTH_WORDS];

   // Misaligned, or any address bit above the word index is set.
   function automatic logic addr_err(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a[31:IDX_W+2] != '0);
   endfunction

   logic               accept;
   logic               acc_fire;
   logic               acc_write;
   logic [IDX_W-1:0]   acc_idx;
   logic [31:0]        acc_wdata;
   logic [3:0]         acc_wstrb;
   logic               acc_err;
   logic [31:0]        acc_rdata;
   logic               mem_we;

   assign accept = (state_q == ST_IDLE) && req_valid_i;

   // Access operands: the latched payload normally, but with zero wait states
   // the access happens on the accept edge itself, so use the live request.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      acc_fire  = 1'b0;
      acc_write = write_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
      acc_wstrb = wstrb_q;
      acc_err   = err_q;
      if (WAIT_CYCLES == 0) begin
         if (accept) begin
            acc_fire  = 1'b1;
            acc_write = req_write_i;
            acc_idx   = req_addr_i[IDX_W+1:2];
            acc_wdata = req_wdata_i;
            acc_wstrb = req_wstrb_i;
            acc_err   = addr_err(req_addr_i);
         end
      end else if ((state_q == ST_WAIT) && (cnt_q == 4'd1)) begin
         acc_fire = 1'b1;
      end
   end

   assign acc_rdata = (acc_write || acc_err) ? 32'h0 : mem_q[acc_idx];

   // rst_n gates the strobe so a zero-wait request presented while reset is
   // asserted cannot reach storage.
   assign mem_we = acc_fire && acc_write && !acc_err && rst_n;

   // NOTE: storage is deliberately not reset; it is a RAM with undefined
   // contents, and leaving it out of reset keeps it mappable to memory macros.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (acc_wstrb[b]) mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         write_q     <= 1'b0;
         idx_q       <= '0;
         wdata_q     <= 32'h0;
         wstrb_q     <= 4'h0;
         err_q       <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values, independent of statement order.
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  write_q     <= req_write_i;
                  idx_q       <= req_addr_i[IDX_W+1:2];
                  wdata_q     <= req_wdata_i;
                  wstrb_q     <= req_wstrb_i;
                  err_q       <= addr_err(req_addr_i);
                  req_ready_q <= 1'b0;
                  if (WAIT_CYCLES == 0) begin
                     state_q     <= ST_RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= acc_rdata;
                     rsp_err_q   <= acc_err;
                  end else begin
                     state_q <= ST_WAIT;
                     cnt_q   <= WAIT_INIT;
                  end
               end
            end
            ST_WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (acc_fire) begin
                  state_q     <= ST_RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= acc_rdata;
                  rsp_err_q   <= acc_err;
               end
            end
            ST_RESP: begin
               // Ready rises only after the handshake edge, so a new request
               // can never be taken in the same cycle as the response.
               if (rsp_ready_i) begin
                  state_q     <= ST_IDLE;
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready_o = req_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Directed bench for dmem_responder. The instance "dut" has two wait states
//   and the instance "dut0" has none. Inputs change on the falling edge and
//   outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
   logic [31:0] req_addr, req_wdata, rsp_rdata;
   logic [3:0]  req_wstrb;

   logic        req_valid0, req_ready0, req_write0, rsp_valid0, rsp_ready0, rsp_err0;
   logic [31:0] req_addr0, req_wdata0, rsp_rdata0;
   logic [3:0]  req_wstrb0;

   int passes = 0;
   int total  = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
   );

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_write_i(req_write0),
      .req_addr_i(req_addr0), .req_wdata_i(req_wdata0), .req_wstrb_i(req_wstrb0),
      .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0),
      .rsp_rdata_o(rsp_rdata0), .rsp_err_o(rsp_err0)
   );

   // One full transaction on "dut". The task holds the response for bp
   // cycles and checks that it stays stable. During that time it also
   // presents a competing store to 0x10, which must not be accepted. The task
   // returns the response data and the latency in cycles.
   task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int bp,
                         output logic [31:0] rd, output logic er, output int lat);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      if (!req_ready) begin
         total++;
         $display("FAIL accept_timeout: req_ready got %b required 1", req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      // Scramble the payload after accept; the response must not depend on it.
      req_valid = 1'b0; req_write = ~wr; req_addr = ~addr; req_wdata = ~wdata; req_wstrb = ~strb;
      lat = 1;
      while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
      rd = rsp_rdata;
      er = rsp_err;
      for (int i = 0; i < bp; i++) begin
         req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10;
         req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'hF;
         @(negedge clk);
         total++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== er || req_ready !== 1'b0)
            $display("FAIL bp_hold[%0d]: valid=%b rdata=%h ready=%b required valid=1 rdata=%h ready=0",
                     i, rsp_valid, rsp_rdata, req_ready, rd);
         else passes++;
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      total++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
         $display("FAIL rsp_drop: valid=%b ready=%b required valid=0 ready=1", rsp_valid, req_ready);
      else passes++;
   endtask

   task automatic test_reset();
      total++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
         $display("FAIL reset_w2: ready=%b valid=%b rdata=%h err=%b required 1 0 00000000 0",
                  req_ready, rsp_valid, rsp_rdata, rsp_err);
      else passes++;
      total++;
      if (req_ready0 !== 1'b1 || rsp_valid0 !== 1'b0 || rsp_rdata0 !== 32'h0 || rsp_err0 !== 1'b0)
         $display("FAIL reset_w0: ready=%b valid=%b rdata=%h err=%b required 1 0 00000000 0",
                  req_ready0, rsp_valid0, rsp_rdata0, rsp_err0);
      else passes++;
   endtask

   task automatic test_store_load();
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lat);
      total++;
      if (lat !== 3 || rd !== 32'h0 || er !== 1'b0)
         $display("FAIL store_10: lat=%0d rdata=%h err=%b required 3 00000000 0", lat, rd, er);
      else passes++;
      do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
      total++;
      if (lat !== 3 || rd !== 32'hDEAD_BEEF || er !== 1'b0)
         $display("FAIL load_10: lat=%0d rdata=%h err=%b required 3 deadbeef 0", lat, rd, er);
      else passes++;
   endtask

   task automatic test_strobes();
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, 32'h20, 32'h1122_3344, 4'hF, 0, rd, er, lat);
      do_req(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 0, rd, er, lat);
      do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
      total++;
      if (rd !== 32'h11BB_33DD || er !== 1'b0)
         $display("FAIL strobe_0101: rdata=%h err=%b required 11bb33dd 0", rd, er);
      else passes++;
      // A zero-strobe store is a legal no-op.
      do_req(1'b1, 32'h20, 32'h0000_0000, 4'h0, 0, rd, er, lat);
      total++;
      if (er !== 1'b0)
         $display("FAIL strobe_zero_err: err=%b required 0", er);
      else passes++;
      do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
      total++;
      if (rd !== 32'h11BB_33DD)
         $display("FAIL strobe_zero_data: rdata=%h required 11bb33dd", rd);
      else passes++;
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, 32'h0, 32'h0BAD_F00D, 4'hF, 0, rd, er, lat);
      do_req(1'b0, 32'h13, 32'h0, 4'h0, 0, rd, er, lat);
      total++;
      if (rd !== 32'h0 || er !== 1'b1 || lat !== 3)
         $display("FAIL err_misaligned_load: rdata=%h err=%b lat=%0d required 00000000 1 3", rd, er, lat);
      else passes++;
      // 0x400 and 0x2 alias word 0 if the error check were ignored.
      do_req(1'b1, 32'h400, 32'h5555_5555, 4'hF, 0, rd, er, lat);
      total++;
      if (rd !== 32'h0 || er !== 1'b1)
         $display("FAIL err_range_store: rdata=%h err=%b required 00000000 1", rd, er);
      else passes++;
      do_req(1'b1, 32'h2, 32'h6666_6666, 4'hF, 0, rd, er, lat);
      total++;
      if (er !== 1'b1)
         $display("FAIL err_misaligned_store: err=%b required 1", er);
      else passes++;
      do_req(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat);
      total++;
      if (rd !== 32'h0BAD_F00D || er !== 1'b0)
         $display("FAIL err_no_update: rdata=%h err=%b required 0badf00d 0", rd, er);
      else passes++;
   endtask

   task automatic test_backpressure();
      logic [31:0] rd; logic er; int lat;
      do_req(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat);
      total++;
      if (rd !== 32'hDEAD_BEEF || er !== 1'b0)
         $display("FAIL bp_load: rdata=%h err=%b required deadbeef 0", rd, er);
      else passes++;
      // The competing store offered during backpressure must not have landed.
      do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
      total++;
      if (rd !== 32'hDEAD_BEEF)
         $display("FAIL bp_no_accept: rdata=%h required deadbeef", rd);
      else passes++;
   endtask

   task automatic test_wait0();
      logic        wr [4]   = '{1'b1, 1'b0, 1'b0, 1'b0};
      logic [31:0] ad [4]   = '{32'h40, 32'h40, 32'h40, 32'h41};
      logic [31:0] exp_rd [4] = '{32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h0};
      logic        exp_er [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      int acc, prev, n;
      prev = 0;
      rsp_ready0 = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         req_valid0 = 1'b1; req_write0 = wr[i]; req_addr0 = ad[i];
         req_wdata0 = 32'hCAFE_F00D; req_wstrb0 = 4'hF;
         n = 0;
         while (!req_ready0 && n < 10) begin @(negedge clk); n++; end
         acc = cyc;
         if (i > 0) begin
            total++;
            if (acc - prev !== 2)
               $display("FAIL w0_throughput[%0d]: spacing=%0d required 2", i, acc - prev);
            else passes++;
         end
         prev = acc;
         @(posedge clk);
         @(negedge clk);
         total++;
         if (rsp_valid0 !== 1'b1 || req_ready0 !== 1'b0 || rsp_rdata0 !== exp_rd[i] || rsp_err0 !== exp_er[i])
            $display("FAIL w0_rsp[%0d]: valid=%b ready=%b rdata=%h err=%b required 1 0 %h %b",
                     i, rsp_valid0, req_ready0, rsp_rdata0, rsp_err0, exp_rd[i], exp_er[i]);
         else passes++;
      end
      req_valid0 = 1'b0;
      @(negedge clk);
      rsp_ready0 = 1'b0;
      total++;
      if (rsp_valid0 !== 1'b0 || req_ready0 !== 1'b1)
         $display("FAIL w0_drain: valid=%b ready=%b required 0 1", rsp_valid0, req_ready0);
      else passes++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic er; int lat, n;
      do_req(1'b1, 32'h30, 32'h0, 4'hF, 0, rd, er, lat);
      // Leave a visible response value behind so the reset clear is observable.
      do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30;
      req_wdata = 32'h1234_5678; req_wstrb = 4'hF;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      total++;
      if (req_ready !== 1'b0)
         $display("FAIL mid_in_wait: ready=%b required 0", req_ready);
      else passes++;
      rst_n = 1'b0;
      #1;
      total++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
         $display("FAIL mid_reset: ready=%b valid=%b rdata=%h err=%b required 1 0 00000000 0",
                  req_ready, rsp_valid, rsp_rdata, rsp_err);
      else passes++;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      do_req(1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er, lat);
      total++;
      if (rd !== 32'h0 || er !== 1'b0)
         $display("FAIL mid_not_committed: rdata=%h err=%b required 00000000 0", rd, er);
      else passes++;
      // Word 0x10 was committed long before the reset and must survive it.
      do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
      total++;
      if (rd !== 32'hDEAD_BEEF)
         $display("FAIL mid_prior_kept: rdata=%h required deadbeef", rd);
      else passes++;
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      rsp_ready = 1'b0;
      req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_wstrb0 = '0;
      rsp_ready0 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_store_load();
      test_strobes();
      test_errors();
      test_backpressure();
      test_wait0();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
